// File: rtl/cpu_pkg.sv
// Shared CPU types: ALU op encoding, RV32I opcode/funct7 constants, issue packet.
package cpu_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } t_alu_op;

  localparam logic [6:0] OPC_REG = 7'b0110011;
  localparam logic [6:0] OPC_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI = 7'b0110111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    t_alu_op     alu_op;
    logic [31:0] in1;
    logic [31:0] in2;
    logic [4:0]  rd;
    logic        illegal;
  } t_issue_pkt;

  // Map funct3 to an ALU op; alt selects SUB/SRA on the two funct3 codes that have one.
  function automatic t_alu_op f3_op(input logic [2:0] f3, input logic alt);
    t_alu_op op;
    case (f3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/alu_decode.sv
// Combinational RV32I integer-compute decoder producing one issue packet.
module alu_decode
  import cpu_pkg::*;
(
  input  logic [31:0] instr,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  output t_issue_pkt  pkt
);

  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic        is_shift;
  logic        legal;
  t_alu_op     op;
  logic [31:0] in1;
  logic [31:0] in2;

  assign opc      = instr[6:0];
  assign f3       = instr[14:12];
  assign f7       = instr[31:25];
  assign is_shift = (f3 == 3'b001) || (f3 == 3'b101);

  // Opcode/funct decode; illegal encodings collapse to a zeroed ADD packet.
  always_comb begin
    legal = 1'b0;
    op    = ALU_ADD;
    in1   = '0;
    in2   = '0;
    case (opc)
      OPC_REG: begin
        legal = (f7 == F7_BASE) ||
                ((f7 == F7_ALT) && ((f3 == 3'b000) || (f3 == 3'b101)));
        op    = f3_op(f3, f7 == F7_ALT);
        in1   = rs1_data;
        in2   = rs2_data;
      end
      OPC_IMM: begin
        in1 = rs1_data;
        if (is_shift) begin
          // shamt lives in the rs2 field; funct7 is an encoding, not immediate
          legal = (f7 == F7_BASE) || ((f7 == F7_ALT) && (f3 == 3'b101));
          op    = f3_op(f3, (f7 == F7_ALT) && (f3 == 3'b101));
          in2   = {27'b0, instr[24:20]};
        end else begin
          legal = 1'b1;
          op    = f3_op(f3, 1'b0);
          in2   = {{20{instr[31]}}, instr[31:20]};
        end
      end
      OPC_LUI: begin
        legal = 1'b1;
        op    = ALU_ADD;
        in1   = '0;
        in2   = {instr[31:12], 12'b0};
      end
      default: legal = 1'b0;
    endcase

    if (legal) pkt = '{alu_op: op, in1: in1, in2: in2, rd: instr[11:7], illegal: 1'b0};
    else       pkt = '{alu_op: ALU_ADD, in1: '0, in2: '0, rd: '0, illegal: 1'b1};
  end

endmodule

// File: rtl/alu_issue.sv
// Decode-and-issue stage: valid/ready in, registered ALU packet out, 2-entry skid.
module alu_issue
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [31:0] instr,
  output logic [4:0]  rf_rs1_addr,
  output logic [4:0]  rf_rs2_addr,
  input  logic [31:0] rf_rs1_data,
  input  logic [31:0] rf_rs2_data,
  output logic        out_valid,
  input  logic        out_ready,
  output t_alu_op     alu_op,
  output logic [31:0] alu_in1,
  output logic [31:0] alu_in2,
  output logic [4:0]  out_rd,
  output logic        out_illegal
);

  localparam t_issue_pkt PKT_RST = '{alu_op: ALU_ADD, in1: '0, in2: '0, rd: '0, illegal: 1'b0};

  t_issue_pkt dec_pkt;
  t_issue_pkt out_q;
  t_issue_pkt skid_q;
  logic       out_vld_q;
  logic       skid_full;
  logic       accept;
  logic       out_free;

  assign rf_rs1_addr = instr[19:15];
  assign rf_rs2_addr = instr[24:20];

  alu_decode u_dec (
    .instr    (instr),
    .rs1_data (rf_rs1_data),
    .rs2_data (rf_rs2_data),
    .pkt      (dec_pkt)
  );

  // Ready depends only on the skid flop (plus reset), never on out_ready.
  assign instr_ready = !skid_full && !rst;
  assign accept      = instr_valid && instr_ready;
  // Output register can take a new entry this cycle (empty or draining).
  assign out_free    = !out_vld_q || out_ready;

  // Output register + skid entry; skid always drains ahead of new input to keep FIFO order.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q     <= PKT_RST;
      skid_q    <= PKT_RST;
      out_vld_q <= 1'b0;
      skid_full <= 1'b0;
    end else if (out_free) begin
      if (skid_full) begin
        // no accept possible here: ready is low while the skid is full
        out_q     <= skid_q;
        out_vld_q <= 1'b1;
        skid_full <= 1'b0;
      end else if (accept) begin
        out_q     <= dec_pkt;
        out_vld_q <= 1'b1;
      end else begin
        out_vld_q <= 1'b0;
      end
    end else if (accept) begin
      skid_q    <= dec_pkt;
      skid_full <= 1'b1;
    end
  end

  assign out_valid   = out_vld_q;
  assign alu_op      = out_q.alu_op;
  assign alu_in1     = out_q.in1;
  assign alu_in2     = out_q.in2;
  assign out_rd      = out_q.rd;
  assign out_illegal = out_q.illegal;

endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue: decode vectors, skid stall stream, reset mid-stall.
module tb_alu_issue;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [4:0]  rf_rs1_addr, rf_rs2_addr;
  logic [31:0] rf_rs1_data, rf_rs2_data;
  logic        out_valid;
  logic        out_ready;
  t_alu_op     alu_op;
  logic [31:0] alu_in1, alu_in2;
  logic [4:0]  out_rd;
  logic        out_illegal;

  int checks = 0;
  int errors = 0;

  alu_issue dut (
    .clk         (clk),
    .rst         (rst),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .rf_rs1_addr (rf_rs1_addr),
    .rf_rs2_addr (rf_rs2_addr),
    .rf_rs1_data (rf_rs1_data),
    .rf_rs2_data (rf_rs2_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .alu_op      (alu_op),
    .alu_in1     (alu_in1),
    .alu_in2     (alu_in2),
    .out_rd      (out_rd),
    .out_illegal (out_illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_pkt(input string tag, input t_alu_op op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd, input logic ill);
    chk({tag, ".valid"}, 32'(out_valid), 32'd1);
    chk({tag, ".op"},    32'(alu_op),    32'(op));
    chk({tag, ".in1"},   alu_in1,        a);
    chk({tag, ".in2"},   alu_in2,        b);
    chk({tag, ".rd"},    32'(out_rd),    32'(rd));
    chk({tag, ".ill"},   32'(out_illegal), 32'(ill));
  endtask

  task automatic drive(input logic [31:0] w, input logic [31:0] r1, input logic [31:0] r2);
    instr       = w;
    rf_rs1_data = r1;
    rf_rs2_data = r2;
    instr_valid = 1'b1;
  endtask

  initial begin
    int exp_idx;
    int k;
    logic acc, drn;

    rst = 1'b1; instr_valid = 1'b0; instr = '0;
    rf_rs1_data = '0; rf_rs2_data = '0; out_ready = 1'b1;
    tick(); tick();
    chk("rst.ready_held", 32'(instr_ready), 32'd0);
    chk("rst.valid",      32'(out_valid),   32'd0);
    rst = 1'b0;
    #1;
    chk("rst.ready",  32'(instr_ready), 32'd1);
    chk("rst.op",     32'(alu_op),      32'(ALU_ADD));
    chk("rst.in1",    alu_in1,          32'd0);
    chk("rst.in2",    alu_in2,          32'd0);
    chk("rst.rd",     32'(out_rd),      32'd0);
    chk("rst.ill",    32'(out_illegal), 32'd0);

    // add x3,x1,x2
    drive(32'h002081B3, 32'd5, 32'd7);
    #1;
    chk("add.rs1a", 32'(rf_rs1_addr), 32'd1);
    chk("add.rs2a", 32'(rf_rs2_addr), 32'd2);
    tick();
    chk_pkt("add", ALU_ADD, 32'd5, 32'd7, 5'd3, 1'b0);

    // srai x5,x6,3
    drive(32'h40335293, 32'h80000000, 32'h1234);
    tick();
    chk_pkt("srai", ALU_SRA, 32'h80000000, 32'd3, 5'd5, 1'b0);

    // addi x1,x0,-1
    drive(32'hFFF00093, 32'd0, 32'h55);
    tick();
    chk_pkt("addi", ALU_ADD, 32'd0, 32'hFFFFFFFF, 5'd1, 1'b0);

    // lui x7,0x12345 (rs1 data must be ignored)
    drive(32'h123453B7, 32'hDEAD, 32'hBEEF);
    tick();
    chk_pkt("lui", ALU_ADD, 32'd0, 32'h12345000, 5'd7, 1'b0);

    // sub x3,x1,x2
    drive(32'h402081B3, 32'd9, 32'd4);
    tick();
    chk_pkt("sub", ALU_SUB, 32'd9, 32'd4, 5'd3, 1'b0);

    // mul x3,x1,x2 -> illegal
    drive(32'h022081B3, 32'd5, 32'd7);
    tick();
    chk_pkt("mul", ALU_ADD, 32'd0, 32'd0, 5'd0, 1'b1);

    // R-type SLL with alt funct7 -> illegal
    drive(32'h402091B3, 32'd5, 32'd7);
    tick();
    chk_pkt("sllalt", ALU_ADD, 32'd0, 32'd0, 5'd0, 1'b1);

    // lw x1,0(x0) -> illegal opcode
    drive(32'h00002083, 32'd5, 32'd7);
    tick();
    chk_pkt("load", ALU_ADD, 32'd0, 32'd0, 5'd0, 1'b1);

    // add x0,x1,x2: rd=x0 is a legal pass-through
    drive(32'h00208033, 32'd1, 32'd2);
    tick();
    chk_pkt("rdx0", ALU_ADD, 32'd1, 32'd2, 5'd0, 1'b0);

    instr_valid = 1'b0;
    tick();
    chk("idle.valid", 32'(out_valid), 32'd0);

    // Stream of 8 addi (rd=i+1, imm=16+i), out_ready low for loop cycles 2..4.
    exp_idx = 0;
    k = 0;
    for (int c = 0; c < 16; c++) begin
      out_ready   = !(c >= 2 && c <= 4);
      instr_valid = (k < 8);
      instr       = {12'(16 + k), 5'd0, 3'b000, 5'(k + 1), 7'b0010011};
      rf_rs1_data = '0;
      #1;
      chk($sformatf("strm.ready%0d", c), 32'(instr_ready),
          32'((c >= 3 && c <= 5) ? 0 : 1));
      acc = instr_valid && instr_ready;
      drn = out_valid && out_ready;
      if (drn) begin
        chk($sformatf("strm.rd%0d", exp_idx),  32'(out_rd), 32'(exp_idx + 1));
        chk($sformatf("strm.in2%0d", exp_idx), alu_in2,     32'(16 + exp_idx));
        exp_idx++;
      end
      tick();
      if (acc) k++;
      // full rate after release: the last instruction goes in at cycle 10
      if (c == 10) chk("strm.rate", 32'(k), 32'd8);
    end
    chk("strm.count", 32'(exp_idx), 32'd8);
    chk("strm.empty", 32'(out_valid), 32'd0);

    // Fill output + skid, then reset mid-stall.
    out_ready = 1'b0;
    drive(32'h00A00493, 32'd0, 32'd0);  // addi x9,x0,10
    tick();
    drive(32'h00B00513, 32'd0, 32'd0);  // addi x10,x0,11
    tick();
    chk("full.ready", 32'(instr_ready), 32'd0);
    chk("full.valid", 32'(out_valid),   32'd1);
    rst = 1'b1;
    tick();
    chk("mrst.valid", 32'(out_valid),   32'd0);
    chk("mrst.ready", 32'(instr_ready), 32'd0);
    rst = 1'b0;
    instr_valid = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("mrst.ready1", 32'(instr_ready), 32'd1);
    chk("mrst.in2",    alu_in2,          32'd0);
    chk("mrst.rd",     32'(out_rd),      32'd0);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk($sformatf("mrst.stale%0d", c), 32'(out_valid), 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
